// File: rtl/tmds_channel_decoder.sv
// tmds_channel_decoder: receive side of one TMDS lane.
// Deserializes the LSB-first bit stream, aligns to 10-bit words using control
// tokens, and decodes each aligned word into a pixel byte or a 2-bit control code.
module tmds_channel_decoder #(
  parameter int unsigned LOCK_TOKENS = 8,
  parameter int unsigned MAX_GAP     = 4095,
  parameter int unsigned GAP_W       = 12
) (
  input  logic       clk_TMDSI,
  input  logic       resetI,
  input  logic       serialI,
  output logic [7:0] dataO,
  output logic [1:0] ctrlO,
  output logic       deO,
  output logic       validO,
  output logic       lockedO
);

  typedef enum logic [1:0] {
    SEARCH,
    VERIFY,
    LOCKED
  } state_t;

  localparam logic [7:0]       LOCK_N  = 8'(LOCK_TOKENS);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(MAX_GAP);
  localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);

  state_t           state_q;
  logic [9:0]       shreg_q;
  logic [3:0]       mod10_q;
  logic [7:0]       hits_q;
  logic [7:0]       hits_d;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gap_d;
  logic             boundary;
  logic             is_tok;
  logic [1:0]       tok_code;
  logic [7:0]       q_bits;
  logic [7:0]       dec_byte;

  assign boundary = (mod10_q == 4'd0);
  assign hits_d   = hits_q + 8'd1;
  assign gap_d    = gap_q + GAP_ONE;

  // Shift register: newest bit enters at the top so the earliest bit ends in bit 0.
  always_ff @(posedge clk_TMDSI) begin
    if (resetI) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= {serialI, shreg_q[9:1]};
    end
  end

  // Control-token recognition on the current 10-bit window.
  always_comb begin
    is_tok   = 1'b0;
    tok_code = 2'b00;
    case (shreg_q)
      10'h354: begin is_tok = 1'b1; tok_code = 2'b00; end
      10'h0AB: begin is_tok = 1'b1; tok_code = 2'b01; end
      10'h154: begin is_tok = 1'b1; tok_code = 2'b10; end
      10'h2AB: begin is_tok = 1'b1; tok_code = 2'b11; end
      default: begin is_tok = 1'b0; tok_code = 2'b00; end
    endcase
  end

  // TMDS data decode: undo optional inversion, then undo the XOR/XNOR chain.
  always_comb begin
    q_bits      = shreg_q[9] ? ~shreg_q[7:0] : shreg_q[7:0];
    dec_byte    = '0;
    dec_byte[0] = q_bits[0];
    for (int unsigned i = 1; i < 8; i++) begin
      dec_byte[i] = shreg_q[8] ? (q_bits[i] ^ q_bits[i-1]) : ~(q_bits[i] ^ q_bits[i-1]);
    end
  end

  // Alignment FSM with word phase, token/gap counters and registered outputs.
  always_ff @(posedge clk_TMDSI) begin
    if (resetI) begin
      state_q <= SEARCH;
      mod10_q <= '0;
      hits_q  <= '0;
      gap_q   <= '0;
      dataO   <= '0;
      ctrlO   <= '0;
      deO     <= 1'b0;
      validO  <= 1'b0;
      lockedO <= 1'b0;
    end else begin
      mod10_q <= (mod10_q == 4'd9) ? 4'd0 : mod10_q + 4'd1;
      validO  <= 1'b0;
      case (state_q)
        SEARCH: begin
          lockedO <= 1'b0;
          // Any-phase hit fixes the word phase: the next boundary is 10 edges away.
          if (is_tok) begin
            mod10_q <= 4'd1;
            hits_q  <= 8'd1;
            state_q <= VERIFY;
          end
        end
        VERIFY: begin
          if (boundary) begin
            if (is_tok) begin
              hits_q <= hits_d;
              if (hits_d == LOCK_N) begin
                state_q <= LOCKED;
                gap_q   <= '0;
                lockedO <= 1'b1;
              end
            end else begin
              state_q <= SEARCH;
              hits_q  <= '0;
            end
          end
        end
        LOCKED: begin
          if (boundary) begin
            validO <= 1'b1;
            deO    <= ~is_tok;
            ctrlO  <= is_tok ? tok_code : 2'b00;
            dataO  <= is_tok ? 8'h00 : dec_byte;
            if (is_tok) begin
              gap_q <= '0;
            end else begin
              gap_q <= gap_d;
              // The word that exhausts the gap budget is still emitted above.
              if (gap_d == GAP_MAX) begin
                state_q <= SEARCH;
                lockedO <= 1'b0;
                hits_q  <= '0;
              end
            end
          end
        end
        default: begin
          state_q <= SEARCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// tb_tmds_channel_decoder: drives aligned word streams into two decoder instances
// (default gap budget and a short one) and checks decoded events against a
// word-level model fed by a TMDS transmit encoder.
module tb_tmds_channel_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_i = 1'b1;
  logic       serial_i = 1'b0;
  logic [7:0] dut_data, gap_data;
  logic [1:0] dut_ctrl, gap_ctrl;
  logic       dut_de, dut_valid, dut_locked;
  logic       gap_de, gap_valid, gap_locked;

  tmds_channel_decoder #(.LOCK_TOKENS(8), .MAX_GAP(4095), .GAP_W(12)) u_dut (
    .clk_TMDSI(clk), .resetI(reset_i), .serialI(serial_i),
    .dataO(dut_data), .ctrlO(dut_ctrl), .deO(dut_de), .validO(dut_valid), .lockedO(dut_locked)
  );

  tmds_channel_decoder #(.LOCK_TOKENS(8), .MAX_GAP(16), .GAP_W(5)) u_gap (
    .clk_TMDSI(clk), .resetI(reset_i), .serialI(serial_i),
    .dataO(gap_data), .ctrlO(gap_ctrl), .deO(gap_de), .validO(gap_valid), .lockedO(gap_locked)
  );

  typedef struct packed {
    logic [31:0] e;
    logic        de;
    logic [1:0]  ctrl;
    logic [7:0]  data;
  } ev_t;

  typedef struct packed {
    logic [31:0] e;
    logic        v;
  } lk_t;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned edges = 0;
  int          disp  = 0;
  logic        last_lk, last_lk_g;
  ev_t         got_ev[$], gap_ev[$], exp_ev[$];
  lk_t         got_lk[$], gap_lk[$], exp_lk[$];
  logic [9:0]  wq[$];
  logic [7:0]  bq[$];

  function automatic int tok_code(input logic [9:0] w);
    case (w)
      10'h354: return 0;
      10'h0AB: return 1;
      10'h154: return 2;
      10'h2AB: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic logic [9:0] tok_word(input int code);
    case (code)
      0: return 10'h354;
      1: return 10'h0AB;
      2: return 10'h154;
      default: return 10'h2AB;
    endcase
  endfunction

  // DVI transmit encoder with running disparity.
  function automatic logic [9:0] encode(input logic [7:0] d);
    int         n1;
    int         n1q;
    int         n0q;
    logic       xm;
    logic [8:0] qm;
    logic [9:0] w;
    n1 = $countones(d);
    xm = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = xm ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = ~xm;
    n1q = $countones(qm[7:0]);
    n0q = 8 - n1q;
    if (disp == 0 || n1q == n0q) begin
      w = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      disp += qm[8] ? (n1q - n0q) : (n0q - n1q);
    end else if ((disp > 0 && n1q > n0q) || (disp < 0 && n0q > n1q)) begin
      w = {1'b1, qm[8], ~qm[7:0]};
      disp += 2 * int'(qm[8]) + n0q - n1q;
    end else begin
      w = {1'b0, qm[8], qm[7:0]};
      disp += -2 * int'(!qm[8]) + n1q - n0q;
    end
    return w;
  endfunction

  task automatic send_bit(input logic b);
    ev_t ev;
    lk_t lk;
    serial_i = b;
    @(posedge clk);
    #1;
    edges++;
    if (dut_valid === 1'b1) begin
      ev.e = edges; ev.de = dut_de; ev.ctrl = dut_ctrl; ev.data = dut_data;
      got_ev.push_back(ev);
    end
    if (gap_valid === 1'b1) begin
      ev.e = edges; ev.de = gap_de; ev.ctrl = gap_ctrl; ev.data = gap_data;
      gap_ev.push_back(ev);
    end
    if (dut_locked !== last_lk) begin
      lk.e = edges; lk.v = dut_locked; got_lk.push_back(lk); last_lk = dut_locked;
    end
    if (gap_locked !== last_lk_g) begin
      lk.e = edges; lk.v = gap_locked; gap_lk.push_back(lk); last_lk_g = gap_locked;
    end
  endtask

  task automatic send_word(input logic [9:0] w);
    for (int i = 0; i < 10; i++) send_bit(w[i]);
  endtask

  task automatic start_test;
    reset_i = 1'b1;
    send_bit(1'b0);
    send_bit(1'b0);
    reset_i = 1'b0;
    wq.delete(); bq.delete();
    got_ev.delete(); gap_ev.delete(); exp_ev.delete();
    got_lk.delete(); gap_lk.delete(); exp_lk.delete();
    last_lk = dut_locked;
    last_lk_g = gap_locked;
    disp = 0;
  endtask

  task automatic add_tok(input int code);
    wq.push_back(tok_word(code));
    bq.push_back(8'h00);
  endtask

  task automatic add_data(input logic [7:0] b);
    wq.push_back(encode(b));
    bq.push_back(b);
  endtask

  // Send every queued word back to back, plus one bit so the last word surfaces.
  task automatic play(output int unsigned s);
    s = edges;
    foreach (wq[k]) send_word(wq[k]);
    send_bit(1'b0);
  endtask

  // Word-level reference: 8 consecutive aligned tokens lock; while locked every
  // word is emitted one edge after its last bit; max_gap non-token words in a row unlock.
  task automatic model(input int unsigned s, input int max_gap);
    int  run = 0;
    int  gap = 0;
    bit  locked = 0;
    int  code;
    ev_t ev;
    lk_t lk;
    exp_ev.delete();
    exp_lk.delete();
    foreach (wq[k]) begin
      code = tok_code(wq[k]);
      lk.e = s + 10 * k + 11;
      if (!locked) begin
        if (code >= 0) begin
          run++;
          if (run == 8) begin
            locked = 1; gap = 0; lk.v = 1'b1; exp_lk.push_back(lk);
          end
        end else begin
          run = 0;
        end
      end else begin
        ev.e    = lk.e;
        ev.de   = (code < 0);
        ev.ctrl = (code < 0) ? 2'b00 : 2'(code);
        ev.data = (code < 0) ? bq[k] : 8'h00;
        exp_ev.push_back(ev);
        if (code >= 0) begin
          gap = 0;
        end else begin
          gap++;
          if (gap == max_gap) begin
            locked = 0; run = 0; lk.v = 1'b0; exp_lk.push_back(lk);
          end
        end
      end
    end
  endtask

  task automatic test_reset;
    reset_i = 1'b1;
    repeat (3) send_bit(1'($urandom_range(0, 1)));
    total++;
    if ({dut_data, dut_ctrl, dut_de, dut_valid, dut_locked} !== 13'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h expected=0", {dut_data, dut_ctrl, dut_de, dut_valid, dut_locked});
    end
    reset_i = 1'b0;
    repeat (8) send_word(10'h354);
    send_bit(1'b0);
    total++;
    if (dut_locked !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_lock got=%b expected=1", dut_locked);
    end
    reset_i = 1'b1;
    send_bit(1'b1);
    total++;
    if ({dut_locked, dut_valid} !== 2'b00) begin
      bad++;
      $display("FAIL reset_mid_lock got=%b expected=00", {dut_locked, dut_valid});
    end
    reset_i = 1'b0;
  endtask

  task automatic test_lock;
    int unsigned s;
    start_test();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    repeat (9) add_tok(0);
    play(s);
    model(s, 4095);
    total++;
    if (got_ev.size() != exp_ev.size() || got_lk.size() != exp_lk.size()) begin
      bad++;
      $display("FAIL lock_counts got=%0d/%0d expected=%0d/%0d", got_ev.size(), got_lk.size(), exp_ev.size(), exp_lk.size());
    end
    for (int i = 0; i < got_ev.size() && i < exp_ev.size(); i++) begin
      total++;
      if (got_ev[i] !== exp_ev[i]) begin
        bad++; $display("FAIL lock_ev[%0d] got=%h expected=%h", i, got_ev[i], exp_ev[i]);
      end
    end
    for (int i = 0; i < got_lk.size() && i < exp_lk.size(); i++) begin
      total++;
      if (got_lk[i] !== exp_lk[i]) begin
        bad++; $display("FAIL lock_lk[%0d] got=%h expected=%h", i, got_lk[i], exp_lk[i]);
      end
    end
  endtask

  task automatic test_sync;
    int unsigned s;
    start_test();
    repeat (8) add_tok($urandom_range(0, 3));
    repeat (2) for (int c = 0; c < 4; c++) add_tok(c);
    play(s);
    model(s, 4095);
    total++;
    if (got_ev.size() != exp_ev.size()) begin
      bad++; $display("FAIL sync_count got=%0d expected=%0d", got_ev.size(), exp_ev.size());
    end
    for (int i = 0; i < got_ev.size() && i < exp_ev.size(); i++) begin
      total++;
      if (got_ev[i] !== exp_ev[i]) begin
        bad++; $display("FAIL sync_ev[%0d] got=%h expected=%h", i, got_ev[i], exp_ev[i]);
      end
    end
    for (int i = 1; i < got_ev.size(); i++) begin
      total++;
      if (got_ev[i].e - got_ev[i-1].e !== 32'd10) begin
        bad++; $display("FAIL sync_period[%0d] got=%0d expected=10", i, got_ev[i].e - got_ev[i-1].e);
      end
    end
    repeat (5) send_bit(1'($urandom_range(0, 1)));
    total++;
    if ({dut_valid, dut_de, dut_ctrl, dut_data} !== {1'b0, 1'b0, 2'b11, 8'h00}) begin
      bad++; $display("FAIL sync_hold got=%h expected=%h", {dut_valid, dut_de, dut_ctrl, dut_data}, {1'b0, 1'b0, 2'b11, 8'h00});
    end
  endtask

  task automatic test_data;
    int unsigned s;
    start_test();
    repeat (8) add_tok($urandom_range(0, 3));
    wq.push_back(10'h100); bq.push_back(8'h00);
    wq.push_back(10'h2FF); bq.push_back(8'hFE);
    for (int b = 0; b < 256; b++) add_data(8'(b));
    repeat (64) add_data(8'($urandom_range(0, 255)));
    play(s);
    model(s, 4095);
    total++;
    if (got_ev.size() != exp_ev.size() || got_lk.size() != exp_lk.size()) begin
      bad++;
      $display("FAIL data_counts got=%0d/%0d expected=%0d/%0d", got_ev.size(), got_lk.size(), exp_ev.size(), exp_lk.size());
    end
    for (int i = 0; i < got_ev.size() && i < exp_ev.size(); i++) begin
      total++;
      if (got_ev[i] !== exp_ev[i]) begin
        bad++; $display("FAIL data_ev[%0d] got=%h expected=%h", i, got_ev[i], exp_ev[i]);
      end
    end
  endtask

  task automatic test_false_lock;
    int unsigned s;
    start_test();
    repeat (5) add_tok($urandom_range(0, 3));
    wq.push_back(10'h100); bq.push_back(8'h00);
    repeat (8) add_tok($urandom_range(0, 3));
    repeat (3) add_data(8'($urandom_range(0, 255)));
    play(s);
    model(s, 4095);
    total++;
    if (got_ev.size() != exp_ev.size() || got_lk.size() != exp_lk.size()) begin
      bad++;
      $display("FAIL false_counts got=%0d/%0d expected=%0d/%0d", got_ev.size(), got_lk.size(), exp_ev.size(), exp_lk.size());
    end
    for (int i = 0; i < got_ev.size() && i < exp_ev.size(); i++) begin
      total++;
      if (got_ev[i] !== exp_ev[i]) begin
        bad++; $display("FAIL false_ev[%0d] got=%h expected=%h", i, got_ev[i], exp_ev[i]);
      end
    end
    for (int i = 0; i < got_lk.size() && i < exp_lk.size(); i++) begin
      total++;
      if (got_lk[i] !== exp_lk[i]) begin
        bad++; $display("FAIL false_lk[%0d] got=%h expected=%h", i, got_lk[i], exp_lk[i]);
      end
    end
  endtask

  task automatic test_loss;
    int unsigned s;
    start_test();
    repeat (8) add_tok($urandom_range(0, 3));
    repeat (15) add_data(8'($urandom_range(0, 255)));
    add_tok($urandom_range(0, 3));
    repeat (16) add_data(8'($urandom_range(0, 255)));
    play(s);
    model(s, 16);
    total++;
    if (gap_ev.size() != exp_ev.size() || gap_lk.size() != exp_lk.size()) begin
      bad++;
      $display("FAIL loss_counts got=%0d/%0d expected=%0d/%0d", gap_ev.size(), gap_lk.size(), exp_ev.size(), exp_lk.size());
    end
    for (int i = 0; i < gap_ev.size() && i < exp_ev.size(); i++) begin
      total++;
      if (gap_ev[i] !== exp_ev[i]) begin
        bad++; $display("FAIL loss_ev[%0d] got=%h expected=%h", i, gap_ev[i], exp_ev[i]);
      end
    end
    for (int i = 0; i < gap_lk.size() && i < exp_lk.size(); i++) begin
      total++;
      if (gap_lk[i] !== exp_lk[i]) begin
        bad++; $display("FAIL loss_lk[%0d] got=%h expected=%h", i, gap_lk[i], exp_lk[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_sync();
    test_data();
    test_false_lock();
    test_loss();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
